spectral_peak_finder: RTL

- Consumes the per-bin power stream (Real^2 + Imag^2, 32-bit unsigned) produced by the magnitude-squared stage after the FFT.
- Scans each frame, delimited by tlast, for the maximum power bin.
- Emits one result per frame: peak power, bin index, length-error flag and frame count, over a valid/ready result interface toward the PS/AXI-Lite register side.

---
 rtl/spectral_peak_finder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spectral_peak_finder.sv
// spectral_peak_finder: scans each tlast-delimited frame of per-bin power
// values and reports the strongest bin, its index, a length-error flag and a
// running frame count over a valid/ready result interface.
// Optional build macro SPECTRAL_PEAK_SKIP_DC_EN: when defined, bin 0 (DC) is
// excluded from the peak search but still counts toward the frame length.
module spectral_peak_finder #(
    parameter int FFT_LEN = 1024,
    parameter int IDX_W   = 10,
    parameter int FCNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic [31:0]       peak_power,
    output logic [IDX_W-1:0]  peak_index,
    output logic              peak_len_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] BIN_MAX   = '1;
    localparam logic [IDX_W:0]   FFT_LEN_W = (IDX_W+1)'(FFT_LEN);

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [31:0]         power_q, power_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                len_err_q, len_err_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [IDX_W-1:0]    bin_q, bin_d;
    // Set once a beat has been accepted at the saturated bin index, i.e. the
    // frame already holds 2^IDX_W beats and any further beat is an overrun.
    logic                over_q, over_d;
    logic [31:0]         max_q, max_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                beat_acc;
    logic [31:0]         cand_max;
    logic [IDX_W-1:0]    cand_idx;
    logic [IDX_W:0]      beats_total;
    logic                len_bad;

    // Running-max candidate for the current beat and next-state decode.
    always_comb begin
        beat_acc    = s_axis_tvalid & ready_q;
        cand_max    = max_q;
        cand_idx    = idx_q;
`ifdef SPECTRAL_PEAK_SKIP_DC_EN
        if (bin_q == '0) begin
            cand_max = '0;
            cand_idx = '0;
        end else if (s_axis_tdata > max_q) begin
            cand_max = s_axis_tdata;
            cand_idx = bin_q;
        end
`else
        if ((bin_q == '0) || (s_axis_tdata > max_q)) begin
            cand_max = s_axis_tdata;
            cand_idx = bin_q;
        end
`endif
        beats_total = {1'b0, bin_q} + {{IDX_W{1'b0}}, 1'b1};
        len_bad     = over_q || (beats_total != FFT_LEN_W);

        state_d   = state_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        power_d   = power_q;
        index_d   = index_q;
        len_err_d = len_err_q;
        fcnt_d    = fcnt_q;
        bin_d     = bin_q;
        over_d    = over_q;
        max_d     = max_q;
        idx_d     = idx_q;

        case (state_q)
            SCAN: begin
                ready_d = 1'b1;
                if (beat_acc) begin
                    if (s_axis_tlast) begin
                        state_d   = HOLD;
                        ready_d   = 1'b0;
                        valid_d   = 1'b1;
                        power_d   = cand_max;
                        index_d   = cand_idx;
                        len_err_d = len_bad;
                        fcnt_d    = fcnt_q + 1'b1;
                        bin_d     = '0;
                        over_d    = 1'b0;
                        max_d     = '0;
                        idx_d     = '0;
                    end else begin
                        max_d = cand_max;
                        idx_d = cand_idx;
                        if (bin_q == BIN_MAX) begin
                            over_d = 1'b1;
                        end else begin
                            bin_d = bin_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                // Input stays stalled in the handshake cycle; scanning
                // resumes on the following cycle.
                if (peak_ready) begin
                    state_d = SCAN;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // State and registered outputs; ready stays low until the first edge
    // after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= SCAN;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            power_q   <= '0;
            index_q   <= '0;
            len_err_q <= 1'b0;
            fcnt_q    <= '0;
            bin_q     <= '0;
            over_q    <= 1'b0;
            max_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            power_q   <= power_d;
            index_q   <= index_d;
            len_err_q <= len_err_d;
            fcnt_q    <= fcnt_d;
            bin_q     <= bin_d;
            over_q    <= over_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign peak_valid    = valid_q;
    assign peak_power    = power_q;
    assign peak_index    = index_q;
    assign peak_len_err  = len_err_q;
    assign frame_cnt     = fcnt_q;

endmodule
